// File: rtl/or_pkg.sv
// Purpose : shared mode encodings and small decode helpers for the OR-reduce accumulator.
// Latency : n/a (types and constant functions only).
// Backpressure : n/a.
//
// Contents: mode_t (2-bit mode typedef), OR_PASS/NOR_PASS/OR_ACC/NOR_ACC,
//           is_acc() / is_nor() field decoders.
package or_pkg;

  typedef enum logic [1:0] {
    OR_PASS  = 2'b00,
    NOR_PASS = 2'b01,
    OR_ACC   = 2'b10,
    NOR_ACC  = 2'b11
  } mode_t;

  // bit 1 selects accumulate vs pass, bit 0 selects inverted output
  function automatic logic is_acc(input mode_t m);
    return m[1];
  endfunction

  function automatic logic is_nor(input mode_t m);
    return m[0];
  endfunction

endpackage

// File: rtl/or_reduce_n.sv
// Purpose : bitwise OR of N W-bit channels packed into one bus.
// Latency : purely combinational, zero cycles.
// Backpressure : none; no handshake of its own.
//
// Ports: i_data  [N*W-1:0]  channel k at bits [k*W +: W]
//        o_red   [W-1:0]    OR of all channels
module or_reduce_n #(
  parameter int W = 8,
  parameter int N = 4
) (
  input  logic [N*W-1:0] i_data,
  output logic [W-1:0]   o_red
);

  always_comb begin
    o_red = '0;
    for (int k = 0; k < N; k++) begin
      o_red = o_red | i_data[k*W +: W];
    end
  end

endmodule

// File: rtl/or_reduce_acc.sv
// Purpose : OR/NOR-reduce N channels per beat, either passing each beat or accumulating per packet.
// Latency : one cycle from accepted beat (pass, or last beat of a packet) to out_valid.
// Backpressure : in_ready = !out_valid || out_ready; a held result stalls input, no bubble on release.
//
// Ports: clk, rst_n (sync, active low)
//        in_valid/in_ready/in_data[N*W]/in_last/mode[2]  input beat handshake
//        out_valid/out_ready/out_data[W]/out_beats[CW]   registered result handshake
module or_reduce_acc
  import or_pkg::*;
#(
  parameter int W  = 8,
  parameter int N  = 4,
  parameter int CW = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N*W-1:0] in_data,
  input  logic           in_last,
  input  logic [1:0]     mode,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   out_data,
  output logic [CW-1:0]  out_beats
);

  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [W-1:0]  r_acc;
  logic [CW-1:0] r_cnt;
  mode_t         r_mode;
  logic          r_open;
  logic          r_out_vld;
  logic [W-1:0]  r_out_dat;
  logic [CW-1:0] r_out_beats;

  logic [W-1:0]  w_red;
  logic          w_accept;
  mode_t         w_mode;
  logic [W-1:0]  w_sum;
  logic [W-1:0]  w_res;
  logic [CW-1:0] w_cnt_inc;
  logic          w_emit;

  or_reduce_n #(.W(W), .N(N)) u_red (
    .i_data (in_data),
    .o_red  (w_red)
  );

  assign in_ready = !r_out_vld || out_ready;
  assign w_accept = in_valid && in_ready;

  // Mode is frozen while a packet is open; a fresh beat samples the live input.
  assign w_mode = r_open ? r_mode : mode_t'(mode);

  // r_acc/r_cnt are zero whenever no packet is open, so pass beats see red and a count of 1.
  assign w_sum     = is_acc(w_mode) ? (r_acc | w_red) : w_red;
  assign w_res     = is_nor(w_mode) ? ~w_sum : w_sum;
  assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + CNT_ONE;
  assign w_emit    = w_accept && (!is_acc(w_mode) || in_last);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_acc       <= '0;
      r_cnt       <= '0;
      r_mode      <= OR_PASS;
      r_open      <= 1'b0;
      r_out_vld   <= 1'b0;
      r_out_dat   <= '0;
      r_out_beats <= '0;
    end else begin
      if (w_emit) begin
        r_out_vld   <= 1'b1;
        r_out_dat   <= w_res;
        r_out_beats <= w_cnt_inc;
      end else if (out_ready) begin
        r_out_vld   <= 1'b0;
      end

      if (w_accept) begin
        if (!r_open) begin
          r_mode <= mode_t'(mode);
        end
        if (w_emit) begin
          r_acc  <= '0;
          r_cnt  <= '0;
          r_open <= 1'b0;
        end else begin
          r_acc  <= w_sum;
          r_cnt  <= w_cnt_inc;
          r_open <= 1'b1;
        end
      end
    end
  end

  assign out_valid = r_out_vld;
  assign out_data  = r_out_dat;
  assign out_beats = r_out_beats;

endmodule
